md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//   Multi-cycle multiply/divide unit with its sequencing controller for the
//   pipelined MIPS core. Sits beside the EX-stage ALU and owns the HI/LO
//   registers. Executes MULT/MULTU/DIV/DIVU over a fixed number of busy
//   cycles and serves MTHI/MTLO. Drives the stall request that freezes the
//   pipeline when a HI/LO consumer or a new md op meets a busy unit.
// PARAMETERS
//   WIDTH        32   operand and HI/LO width
//   MULT_CYCLES  5    busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10   busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk       in   1      clock, all state on rising edge
//   reset     in   1      asynchronous, active-low; 0 clears all state immediately
//   start     in   1      EX-stage md instruction valid this cycle
//   md_op     in   3      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 no-op
//   rs_val    in   WIDTH  operand A / MTHI,MTLO source
//   rt_val    in   WIDTH  operand B
//   hilo_use  in   1      ID/EX instruction reads HI/LO or is an md op
//   busy      out  1      unit running a multiply/divide
//   stall     out  1      busy & hilo_use (combinational)
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, count=0, busy=0, hi=0, lo=0,
//     pending results discarded; reset mid-operation aborts cleanly.
//   States: IDLE, RUN.
//   IDLE & start & md_op in {0..3} at edge T: latch operands, compute result
//     into pending_hi/pending_lo, load count=N-1 (N=MULT_CYCLES or
//     DIV_CYCLES), go RUN. busy=1 from cycle T+1 for exactly N cycles.
//   RUN: count decrements each edge; at edge with count==0: hi<=pending_hi,
//     lo<=pending_lo, go IDLE. New hi/lo and busy=0 visible in the same
//     cycle (T+N+1).
//   IDLE & start & md_op==4: hi<=rs_val next edge; md_op==5: lo<=rs_val.
//     No busy cycles. md_op 6-7: no effect.
//   start while RUN: ignored (stall must have frozen the pipeline); a bench
//     assertion flags it as a protocol error. HI/LO and count unaffected.
//   Arithmetic:
//     MULT  {hi,lo} = signed(A)*signed(B), full 2*WIDTH product.
//     MULTU {hi,lo} = unsigned A*B.
//     DIV   lo = quotient truncated toward zero; hi = remainder, sign of
//           dividend A. A=-2^(WIDTH-1), B=-1: lo=0x80000000, hi=0.
//     DIVU  unsigned quotient/remainder.
//     B==0 for DIV/DIVU: still busy N cycles, hi/lo left unchanged.
//   stall is purely combinational from busy and hilo_use; no registered lag.
//   hi/lo outputs are direct register outputs; no bypass of pending values.
// TESTING
//   MULT A=0xFFFFFFFE(-2),B=3, start 1 cycle -> busy high cycles 1..5,
//     cycle 6 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   MULTU A=0xFFFFFFFF,B=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE,
//     lo=0x00000001.
//   DIV A=-7,B=2 -> busy 10 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//   DIVU A=5,B=0 with hi=0x11,lo=0x22 preloaded via MTHI/MTLO -> busy 10
//     cycles, hi=0x11, lo=0x22 unchanged; MTHI/MTLO each update in 1 cycle.
//   hilo_use=1 during DIV -> stall=1 exactly while busy; second start while
//     busy -> ignored, hi/lo equal first-op result, protocol assertion fires.
//   reset pulled low at busy cycle 3 of MULT -> busy,hi,lo=0 without waiting
//     for clk; after release, no stale result ever reaches hi/lo.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
//
// Multi-cycle multiply/divide unit and its sequencing controller for the
// pipelined MIPS core. It sits beside the EX-stage ALU and owns the HI/LO
// registers. MULT/MULTU/DIV/DIVU run for a fixed number of busy cycles, and
// MTHI/MTLO write HI/LO directly. While the unit is busy, any instruction that
// touches HI/LO (including a new md op) raises stall so the pipeline freezes.
//
// Ports:
//   clk       in   1      clock, all state updates on the rising edge
//   reset     in   1      asynchronous, active-low; 0 clears all state at once
//   start     in   1      EX-stage md instruction valid this cycle
//   md_op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                         6-7 no-op
//   rs_val    in   WIDTH  operand A, also the MTHI/MTLO source
//   rt_val    in   WIDTH  operand B
//   hilo_use  in   1      ID/EX instruction reads HI/LO or is an md op
//   busy      out  1      unit is running a multiply/divide (registered)
//   stall     out  1      busy & hilo_use (combinational)
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// -----------------------------------------------------------------------------
module md_unit_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_use,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Counter is sized for the longer of the two latencies.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pending_hi;
  logic [WIDTH-1:0] pending_lo;
  logic             pending_write;

  // Combinational datapath results, captured into the pending registers at
  // the start edge. The busy cycles model the latency of the real iterative
  // hardware; the visible HI/LO only change when the count expires.
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_write;

  // Multiply: sign- or zero-extend both operands to 2*WIDTH. The low
  // 2*WIDTH bits of the extended product are the exact full-width result in
  // both the signed and the unsigned case.
  always_comb begin
    ext_a   = '0;
    ext_b   = '0;
    product = '0;
    if (md_op == OP_MULT) begin
      ext_a = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
      ext_b = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    end else begin
      ext_a = {{WIDTH{1'b0}}, rs_val};
      ext_b = {{WIDTH{1'b0}}, rt_val};
    end
    product = ext_a * ext_b;
  end

  // Divide: a single unsigned divider works on magnitudes and signs are
  // restored afterwards. This gives truncation toward zero and a remainder
  // with the dividend's sign, and it makes the most-negative / -1 case come
  // out as 0x80..0 / 0 without relying on signed-overflow behaviour.
  // A zero divisor is replaced by 1 so the divider never sees /0; the result
  // is then discarded via res_write.
  always_comb begin
    div_signed = (md_op == OP_DIV);
    a_neg      = div_signed & rs_val[WIDTH-1];
    b_neg      = div_signed & rt_val[WIDTH-1];
    mag_a      = a_neg ? (~rs_val + 1'b1) : rs_val;
    mag_b      = b_neg ? (~rt_val + 1'b1) : rt_val;
    if (rt_val == '0) begin
      mag_b = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    quot_mag   = mag_a / mag_b;
    rem_mag    = mag_a % mag_b;
    quot       = (a_neg ^ b_neg) ? (~quot_mag + 1'b1) : quot_mag;
    rem        = a_neg ? (~rem_mag + 1'b1) : rem_mag;
  end

  // Select the pending result for the op being launched. Divides by zero
  // still occupy the unit but leave HI/LO untouched.
  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_write = 1'b1;
    if (md_op[1]) begin
      res_hi    = rem;
      res_lo    = quot;
      res_write = (rt_val != '0);
    end else begin
      res_hi    = product[2*WIDTH-1:WIDTH];
      res_lo    = product[WIDTH-1:0];
    end
  end

  // Sequencing FSM. busy is a registered output that mirrors the RUN state.
  // A start seen while running is dropped: the stall output should already
  // have frozen the pipeline, so such a start is a protocol error upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      busy          <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      pending_hi    <= '0;
      pending_lo    <= '0;
      pending_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                pending_hi    <= res_hi;
                pending_lo    <= res_lo;
                pending_write <= res_write;
                count         <= MULT_LOAD;
                busy          <= 1'b1;
                state         <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pending_hi    <= res_hi;
                pending_lo    <= res_lo;
                pending_write <= res_write;
                count         <= DIV_LOAD;
                busy          <= 1'b1;
                state         <= RUN;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (count == '0) begin
            if (pending_write) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
            pending_write <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // No registered lag: the freeze must take effect in the same cycle the
  // HI/LO consumer reaches ID/EX.
  assign stall = busy & hilo_use;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_unit_ctrl
//
// Directed self-checking bench for md_unit_ctrl. Each scenario task drives
// its own vectors and compares against hand-computed values. Inputs change
// 1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_md_unit_ctrl;

  localparam int WIDTH = 32;
  localparam int MC    = 5;
  localparam int DC    = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hilo_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks;
  int failures;
  int proto_errs;

  md_unit_ctrl #(
    .WIDTH(WIDTH),
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .hilo_use(hilo_use),
    .busy(busy),
    .stall(stall),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a start presented while the unit is busy means the
  // pipeline ignored stall. Counted so the scenario can confirm it fired.
  always @(posedge clk) begin
    if (reset && start && busy) begin
      proto_errs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; on return the DUT is in its first busy cycle.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    md_op  = 3'd7;
  endtask

  // Counts busy cycles until idle, bounded so a stuck DUT cannot hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    md_op    = 3'd7;
    rs_val   = '0;
    rt_val   = '0;
    hilo_use = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall); end
    checks++;
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
    checks++;
    if (lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
    tick();
    #2 reset = 1'b1;
    hilo_use = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++;
    if (n != MC) begin failures++; $display("[TB] FAIL mult_cycles got=%0d exp=%0d", n, MC); end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++;
    if (lo !== 32'hFFFF_FFFA) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_multu();
    int n;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++;
    if (n != MC) begin failures++; $display("[TB] FAIL multu_cycles got=%0d exp=%0d", n, MC); end
    checks++;
    if (hi !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++;
    if (lo !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (n != DC) begin failures++; $display("[TB] FAIL div_cycles got=%0d exp=%0d", n, DC); end
    checks++;
    if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++;
    if (lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++;
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL div_ovf_hi got=%h exp=0", hi); end
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (lo !== 32'h7FFF_FFFC) begin failures++; $display("[TB] FAIL divu_lo got=%h exp=7ffffffc", lo); end
    checks++;
    if (hi !== 32'h1) begin failures++; $display("[TB] FAIL divu_hi got=%h exp=1", hi); end
  endtask

  task automatic test_mthi_mtlo_divzero();
    int n;
    issue(3'd4, 32'h11, 32'h0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mthi_busy got=%0b exp=0", busy); end
    checks++;
    if (hi !== 32'h11) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=11", hi); end
    issue(3'd5, 32'h22, 32'h0);
    checks++;
    if (lo !== 32'h22) begin failures++; $display("[TB] FAIL mtlo_lo got=%h exp=22", lo); end
    issue(3'd6, 32'h99, 32'h0);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL nop_effect got=%h/%h/%0b exp=11/22/0", hi, lo, busy);
    end
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    checks++;
    if (n != DC) begin failures++; $display("[TB] FAIL divz_cycles got=%0d exp=%0d", n, DC); end
    checks++;
    if (hi !== 32'h11) begin failures++; $display("[TB] FAIL divz_hi got=%h exp=11", hi); end
    checks++;
    if (lo !== 32'h22) begin failures++; $display("[TB] FAIL divz_lo got=%h exp=22", lo); end
  endtask

  task automatic test_stall();
    int n;
    hilo_use = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL stall_idle got=%0b exp=0", stall); end
    issue(3'd2, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 40) begin
      checks++;
      if (stall !== 1'b1) begin failures++; $display("[TB] FAIL stall_busy cyc=%0d got=%0b exp=1", n, stall); end
      n++;
      tick();
    end
    checks++;
    if (n != DC) begin failures++; $display("[TB] FAIL stall_cycles got=%0d exp=%0d", n, DC); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL stall_after got=%0b exp=0", stall); end
    hilo_use = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int proto_before;
    proto_before = proto_errs;
    issue(3'd3, 32'd100, 32'd7);
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL b2b_nouse_stall got=%0b exp=0", stall); end
    tick();
    start  = 1'b1;
    md_op  = 3'd0;
    rs_val = 32'd3;
    rt_val = 32'd3;
    tick();
    start  = 1'b0;
    md_op  = 3'd7;
    wait_idle(n);
    checks++;
    if (n + 3 != DC) begin failures++; $display("[TB] FAIL b2b_cycles got=%0d exp=%0d", n + 3, DC); end
    checks++;
    if (lo !== 32'd14) begin failures++; $display("[TB] FAIL b2b_lo got=%h exp=0000000e", lo); end
    checks++;
    if (hi !== 32'd2) begin failures++; $display("[TB] FAIL b2b_hi got=%h exp=00000002", hi); end
    checks++;
    if (proto_errs - proto_before != 1) begin
      failures++; $display("[TB] FAIL b2b_protocol got=%0d exp=1", proto_errs - proto_before);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || lo !== 32'd14) begin
      failures++; $display("[TB] FAIL b2b_no_replay got=%0b/%h exp=0/0000000e", busy, lo);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(3'd4, 32'hAA, 32'h0);
    issue(3'd5, 32'hBB, 32'h0);
    issue(3'd0, 32'd7, 32'd9);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++;
    if (hi !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hi got=%h exp=0", hi); end
    checks++;
    if (lo !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_lo got=%h exp=0", lo); end
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_stale got=%h/%h/%0b exp=0/0/0", hi, lo, busy);
    end
    issue(3'd1, 32'd2, 32'd3);
    wait_idle(n);
    checks++;
    if (lo !== 32'd6 || hi !== 32'd0) begin
      failures++; $display("[TB] FAIL rstmid_recover got=%h/%h exp=0/6", hi, lo);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    proto_errs = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo_divzero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
